serial_add_ctrl: RTL and testbench

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_ctrl.sv | 129 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: drives an external 1-bit full adder LSB first, one bit per cycle.
// Define SERIAL_ADD_OVF_EN to add the signed-overflow output ovf.
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_c,
    input  logic             fa_s,
    input  logic             fa_co,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;
    localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, b_q, sum_q;
    logic [CntW-1:0]   cnt_q;
    logic [IdxW-1:0]   idx;
    logic              carry_q;
    logic              cout_q;
    logic              accept;
    logic              last_bit;

    assign idx      = cnt_q[IdxW-1:0];
    assign accept   = (state_q == StIdle) && start;
    assign last_bit = (cnt_q == CntW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (last_bit) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        fa_a = 1'b0;
        fa_b = 1'b0;
        fa_c = 1'b0;
        unique case (state_q)
            StRun: begin
                busy = 1'b1;
                fa_a = a_q[idx];
                fa_b = b_q[idx];
                fa_c = carry_q;
            end
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else if (accept) begin
            a_q     <= a_in;
            b_q     <= b_in;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= cin;
            cout_q  <= 1'b0;
        end else if (state_q == StRun) begin
            sum_q[idx] <= fa_s;
            carry_q    <= fa_co;
            cnt_q      <= cnt_q + CntW'(1);
            if (last_bit) begin
                cout_q <= fa_co;
            end
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    logic ovf_q;

    // On the MSB edge carry_q is the carry into the MSB and fa_co the carry out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (accept) begin
            ovf_q <= 1'b0;
        end else if ((state_q == StRun) && last_bit) begin
            ovf_q <= carry_q ^ fa_co;
        end
    end

    assign ovf = ovf_q;
`endif

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl (WIDTH=8) with a behavioural full adder.
module tb_serial_add_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a_in, b_in;
    logic       cin;
    logic       fa_a, fa_b, fa_c, fa_s, fa_co;
    logic       busy, done, cout;
    logic [7:0] sum;
`ifdef SERIAL_ADD_OVF_EN
    logic       ovf;
`endif

    int checks = 0;
    int errors = 0;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a_in  (a_in),
        .b_in  (b_in),
        .cin   (cin),
        .fa_a  (fa_a),
        .fa_b  (fa_b),
        .fa_c  (fa_c),
        .fa_s  (fa_s),
        .fa_co (fa_co),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
`ifdef SERIAL_ADD_OVF_EN
        .ovf   (ovf),
`endif
        .cout  (cout)
    );

    assign fa_s  = fa_a ^ fa_b ^ fa_c;
    assign fa_co = (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept edge counts as edge 1, so done is seen after edge 9 with busy for 8 cycles.
    // inj > 0 pulses start with other operands after that many edges.
    task automatic do_add(input logic [7:0] a, input logic [7:0] b, input logic c,
                          input logic [7:0] exp_sum, input logic exp_cout, input logic exp_ovf,
                          input int inj, input string tag);
        int edges;
        int busy_cycles;
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        cin   = c;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a_in  = 8'h00;
        b_in  = 8'h00;
        cin   = 1'b0;
        check({31'd0, fa_a}, {31'd0, a[0]}, {tag, "_fa_a0"});
        check({31'd0, fa_b}, {31'd0, b[0]}, {tag, "_fa_b0"});
        check({31'd0, fa_c}, {31'd0, c}, {tag, "_fa_c0"});
        edges = 1;
        busy_cycles = 0;
        while (!done && edges < 20) begin
            if (busy) busy_cycles++;
            if (inj > 0 && edges == inj) begin
                start = 1'b1;
                a_in  = 8'hAA;
                b_in  = 8'h55;
                cin   = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            edges++;
        end
        start = 1'b0;
        check(edges, 9, {tag, "_done_edge"});
        check(busy_cycles, 8, {tag, "_busy_cycles"});
        check({24'd0, sum}, {24'd0, exp_sum}, {tag, "_sum"});
        check({31'd0, cout}, {31'd0, exp_cout}, {tag, "_cout"});
`ifdef SERIAL_ADD_OVF_EN
        check({31'd0, ovf}, {31'd0, exp_ovf}, {tag, "_ovf"});
`else
        if (exp_ovf === 1'bx) $display("unexpected ovf argument");
`endif
        @(posedge clk);
        #1;
        check({31'd0, done}, 32'd0, {tag, "_done_pulse"});
        check({31'd0, busy}, 32'd0, {tag, "_idle_busy"});
        check({31'd0, fa_a | fa_b | fa_c}, 32'd0, {tag, "_idle_fa"});
        check({24'd0, sum}, {24'd0, exp_sum}, {tag, "_sum_hold"});
        check({31'd0, cout}, {31'd0, exp_cout}, {tag, "_cout_hold"});
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a_in  = 8'h00;
        b_in  = 8'h00;
        cin   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check({31'd0, busy}, 32'd0, "rst_busy");
        check({31'd0, done}, 32'd0, "rst_done");
        check({24'd0, sum}, 32'd0, "rst_sum");
        check({31'd0, cout}, 32'd0, "rst_cout");
        check({29'd0, fa_a, fa_b, fa_c}, 32'd0, "rst_fa");
        @(negedge clk);
        rst_n = 1'b1;

        do_add(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 0, "add_0f_01");
        do_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0, "add_ff_01");
        do_add(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0, "add_7f_01");
        do_add(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 0, "add_cin");
        do_add(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0, 0, "add_a5_5a");
        do_add(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 4, "start_ignored");
        repeat (3) @(posedge clk);
        #1;
        check({31'd0, busy}, 32'd0, "no_queued_run");

        // Reset asserted between edges in the 4th RUN cycle.
        @(negedge clk);
        a_in  = 8'hFF;
        b_in  = 8'hFF;
        cin   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check({31'd0, busy}, 32'd1, "pre_rst_busy");
        rst_n = 1'b0;
        #1;
        check({31'd0, busy}, 32'd0, "mid_rst_busy");
        check({31'd0, done}, 32'd0, "mid_rst_done");
        check({24'd0, sum}, 32'd0, "mid_rst_sum");
        check({31'd0, cout}, 32'd0, "mid_rst_cout");
        check({29'd0, fa_a, fa_b, fa_c}, 32'd0, "mid_rst_fa");
`ifdef SERIAL_ADD_OVF_EN
        check({31'd0, ovf}, 32'd0, "mid_rst_ovf");
`endif
        #1;
        rst_n = 1'b1;
        do_add(8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 0, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
